ps_bc_slct_pipe: RTL and testbench
==================================

# ps_bc_slct_pipe

Parametrised bus-connect select controller for the program sequencer decode stage. It decodes instruction class and universal-register addresses into the DRR source select and the DI select for the bus-connect. The DI select is delivered through a stall- and flush-aware pipeline of configurable depth. A two-beat state machine handles double-word transfers. It replaces the fixed single-register select control in the decode path.

## Interface
- `DI_DEPTH`, default 1: number of register stages on the DI select path (1..4).
- `UREG_AW`, default 4: width of the universal-register address fields (4..6).
- `clk_dcd`  in  1  decode clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps_stall`  in  1  freeze pipeline and FSM.
- `ps_flush`  in  1  squash DI pipeline contents and abort any double beat.
- `ps_pshstck`, `ps_popstck`, `ps_imminst`, `ps_dmimminst`, `ps_dmiaddinst`, `ps_dminst`, `ps_urgtrnsinst`, `ps_dm_wrb`  in  1 each  decoded instruction class and DM direction (1 = write).
- `ps_dblinst`  in  1  double-word transfer qualifier (two beats).
- `ps_ureg1_add`, `ps_ureg2_add`  in  UREG_AW  source universal-register addresses.
- `ps_bc_drr_slct`  out  2  DRR source select (combinational in beat 1, registered in beat 2).
- `ps_bc_di_slct`  out  2  DI select, delayed DI_DEPTH cycles.
- `ps_bc_di_vld`  out  1  DI select at the output is a live instruction's select.
- `ps_bc_busy`  out  1  second beat in progress; upstream must hold decode.
- `ps_bc_beat`  out  1  0 = first/only beat, 1 = second beat.

## Operation
- Decode priority, highest first:
  - imm or dmimm: DI=10, DRR=11.
  - popstck: DI=01, DRR=01.
  - (dm or dmiadd) and read: DI=00, DRR=11.
  - (dm or dmiadd) and write, or pshstck: DI=01, DRR=map(ureg1).
  - urgtrns: DI=01, DRR=map(ureg2).
  - none of the above: DI=11, DRR=11, live=0. Every other branch has live=1.
- map(a):
  - Upper UREG_AW-4 bits nonzero: 11.
  - Otherwise, low nibble 0: 10; 6 or 7: 01; 1 or 2: 00; any other value: 11.
- DI pipeline: DI_DEPTH stages of {code, live}. Stage 0 loads the decoded pair. The last stage drives `ps_bc_di_slct` and `ps_bc_di_vld`.
- FSM `S_IDLE`: `ps_dblinst` with a live decode whose DRR path uses a ureg → latch the used address with LSB forced to 1 and the DI code, then go to `S_BEAT2`. `ps_dblinst` with any other decode is ignored.
- FSM `S_BEAT2`:
  - DRR = map(latched address); DI = latched code, live = 1.
  - `ps_bc_busy` = 1 and `ps_bc_beat` = 1; decode inputs are ignored.
  - Next state is `S_IDLE`.
- Stall: all registers hold. `ps_bc_drr_slct` still tracks the current inputs, or the latched address in `S_BEAT2`.
- Flush: all DI stages load {11, 0} and the FSM goes to `S_IDLE`. The decode on the flush cycle is discarded.
- Priority: reset > flush > stall > normal.

## Timing
- Reset values: every DI stage {11, 0}; FSM `S_IDLE`. Resulting outputs: `ps_bc_di_slct`=11, `ps_bc_di_vld`=0, `ps_bc_busy`=0, `ps_bc_beat`=0, `ps_bc_drr_slct` = decode of the current inputs.
- DRR latency 0 in beat 1. In beat 2 it is registered and valid the cycle after the first beat.
- DI latency is exactly DI_DEPTH unstalled cycles. A stall of N cycles adds N.
- A double-word transfer occupies two consecutive unstalled cycles. A stall in `S_BEAT2` extends that beat.
- Flush during `S_BEAT2` aborts the second beat: it never reaches the DI output, and busy drops the next cycle.
- Reset mid-beat: the FSM returns to `S_IDLE` the next cycle and the DI pipeline is cleared.

## Configuration
- `PS_BC_DBL_EN` defined: double-beat FSM, latch, `ps_bc_busy` and `ps_bc_beat` are active as described.
- Not defined: `ps_dblinst` is ignored, the FSM and latch are not built, and `ps_bc_busy` and `ps_bc_beat` are tied to 0.

## Structure
- Shared package `ps_bc_pkg`:
  - DI codes: `DI_DM`=00, `DI_UREG`=01, `DI_IMM`=10, `DI_IDLE`=11.
  - DRR codes: 00, 01, 10, `DRR_DFLT`=11.
  - FSM state enum.
  - Function `ureg_to_drr` (the map above).
- One sub-module `ps_bc_di_pipe`: parametrised {code, live} shift pipeline with hold and clear. It is instantiated with `DI_DEPTH`.

## Test plan
- Reset held 2 cycles, then released with no instruction → DI=11, vld=0, busy=0 throughout.
- DI_DEPTH=3, dminst read at cycle 0 → DRR=11 immediately; DI=00 with vld=1 at cycle 3.
- dminst write with ureg1=6 (DRR=01), then urgtrns with ureg2=2 (DRR=00), then pshstck with ureg1=0 (DRR=10), then imm with pshstck asserted (DI=10, DRR=11, imm priority wins).
- `PS_BC_DBL_EN`, dblinst + dm write with ureg1=6:
  - Beat 1: DRR=01, busy=0.
  - Beat 2: address 7 → DRR=01, busy=1, beat=1.
  - Two consecutive DI=01 with vld=1.
- Double beat with a 2-cycle stall in beat 2, then a flush in beat 2 of a second transfer → first transfer: beat 2 is held 2 extra cycles. Second transfer: vld=0 for the squashed beat, busy=0 the next cycle.
- UREG_AW=6, urgtrns with ureg2=6'h16 → DRR=11 (upper bits nonzero).

Source files
------------

// File: rtl/ps_bc_slct_pipe_pkg.sv
// rtl/ps_bc_slct_pipe_pkg.sv - shared codes, FSM states and ureg map for the bus-connect select controller
package ps_bc_pkg;

    localparam logic [1:0] DI_DM    = 2'b00;
    localparam logic [1:0] DI_UREG  = 2'b01;
    localparam logic [1:0] DI_IMM   = 2'b10;
    localparam logic [1:0] DI_IDLE  = 2'b11;

    localparam logic [1:0] DRR_SEL0 = 2'b00;
    localparam logic [1:0] DRR_SEL1 = 2'b01;
    localparam logic [1:0] DRR_SEL2 = 2'b10;
    localparam logic [1:0] DRR_DFLT = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BEAT2 = 1'b1
    } bc_state_e;

    // Callers zero-extend the address to 6 bits, so bits [5:4] are the bits above the nibble.
    function automatic logic [1:0] ureg_to_drr(input logic [5:0] addr);
        logic [1:0] res;
        res = DRR_DFLT;
        if (addr[5:4] == 2'b00) begin
            case (addr[3:0])
                4'h0:       res = DRR_SEL2;
                4'h6, 4'h7: res = DRR_SEL1;
                4'h1, 4'h2: res = DRR_SEL0;
                default:    res = DRR_DFLT;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/ps_bc_slct_pipe_if.sv
// rtl/ps_bc_slct_pipe_if.sv - decode-side signal bundle for the bus-connect select controller
interface ps_bc_slct_pipe_if #(
    parameter int UREG_AW = 4
);
    logic               ps_stall;
    logic               ps_flush;
    logic               ps_pshstck;
    logic               ps_popstck;
    logic               ps_imminst;
    logic               ps_dmimminst;
    logic               ps_dmiaddinst;
    logic               ps_dminst;
    logic               ps_urgtrnsinst;
    logic               ps_dm_wrb;
    logic               ps_dblinst;
    logic [UREG_AW-1:0] ps_ureg1_add;
    logic [UREG_AW-1:0] ps_ureg2_add;
    logic [1:0]         ps_bc_drr_slct;
    logic [1:0]         ps_bc_di_slct;
    logic               ps_bc_di_vld;
    logic               ps_bc_busy;
    logic               ps_bc_beat;

    modport master (
        output ps_stall, ps_flush, ps_pshstck, ps_popstck, ps_imminst, ps_dmimminst,
               ps_dmiaddinst, ps_dminst, ps_urgtrnsinst, ps_dm_wrb, ps_dblinst,
               ps_ureg1_add, ps_ureg2_add,
        input  ps_bc_drr_slct, ps_bc_di_slct, ps_bc_di_vld, ps_bc_busy, ps_bc_beat
    );

    modport slave (
        input  ps_stall, ps_flush, ps_pshstck, ps_popstck, ps_imminst, ps_dmimminst,
               ps_dmiaddinst, ps_dminst, ps_urgtrnsinst, ps_dm_wrb, ps_dblinst,
               ps_ureg1_add, ps_ureg2_add,
        output ps_bc_drr_slct, ps_bc_di_slct, ps_bc_di_vld, ps_bc_busy, ps_bc_beat
    );
endinterface

// File: rtl/ps_bc_slct_pipe_di_pipe.sv
// rtl/ps_bc_slct_pipe_di_pipe.sv - {code, live} shift pipeline with hold and clear
module ps_bc_di_pipe
    import ps_bc_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk_dcd,
    input  logic       reset,
    input  logic       hold,
    input  logic       clear,
    input  logic [1:0] in_code,
    input  logic       in_live,
    output logic [1:0] out_code,
    output logic       out_live
);
    logic [1:0] code_q [DEPTH];
    logic       live_q [DEPTH];

    // Clear wins over hold so a flush during a stall still squashes the pipe.
    always_ff @(posedge clk_dcd) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= DI_IDLE;
                live_q[i] <= 1'b0;
            end
        end else if (!hold) begin
            code_q[0] <= in_code;
            live_q[0] <= in_live;
            for (int i = 1; i < DEPTH; i++) begin
                code_q[i] <= code_q[i-1];
                live_q[i] <= live_q[i-1];
            end
        end
    end

    assign out_code = code_q[DEPTH-1];
    assign out_live = live_q[DEPTH-1];

endmodule

// File: rtl/ps_bc_slct_pipe.sv
// rtl/ps_bc_slct_pipe.sv - bus-connect DRR/DI select decode with DI pipeline; double beat under PS_BC_DBL_EN
module ps_bc_slct_pipe
    import ps_bc_pkg::*;
#(
    parameter int DI_DEPTH = 1,
    parameter int UREG_AW  = 4
) (
    input  logic              clk_dcd,
    input  logic              reset,
    ps_bc_slct_pipe_if.slave  bc
);
    logic [UREG_AW-1:0] ureg1;
    logic [UREG_AW-1:0] ureg2;
    logic [5:0]         ureg1_x;
    logic [5:0]         ureg2_x;

    logic [1:0] dec_di;
    logic [1:0] dec_drr;
    logic       dec_live;
    logic       dec_uses_ureg;
    logic [5:0] dec_addr;

    logic [1:0] pipe_code;
    logic       pipe_live;
    logic [1:0] drr_out;
    logic       busy;
    logic       beat;

    assign ureg1   = bc.ps_ureg1_add;
    assign ureg2   = bc.ps_ureg2_add;
    assign ureg1_x = 6'(ureg1);
    assign ureg2_x = 6'(ureg2);

    always_comb begin
        dec_di        = DI_IDLE;
        dec_drr       = DRR_DFLT;
        dec_live      = 1'b0;
        dec_uses_ureg = 1'b0;
        dec_addr      = 6'd0;
        if (bc.ps_imminst || bc.ps_dmimminst) begin
            dec_di   = DI_IMM;
            dec_live = 1'b1;
        end else if (bc.ps_popstck) begin
            dec_di   = DI_UREG;
            dec_drr  = DRR_SEL1;
            dec_live = 1'b1;
        end else if ((bc.ps_dminst || bc.ps_dmiaddinst) && !bc.ps_dm_wrb) begin
            dec_di   = DI_DM;
            dec_live = 1'b1;
        end else if (((bc.ps_dminst || bc.ps_dmiaddinst) && bc.ps_dm_wrb) || bc.ps_pshstck) begin
            dec_di        = DI_UREG;
            dec_addr      = ureg1_x;
            dec_drr       = ureg_to_drr(ureg1_x);
            dec_live      = 1'b1;
            dec_uses_ureg = 1'b1;
        end else if (bc.ps_urgtrnsinst) begin
            dec_di        = DI_UREG;
            dec_addr      = ureg2_x;
            dec_drr       = ureg_to_drr(ureg2_x);
            dec_live      = 1'b1;
            dec_uses_ureg = 1'b1;
        end
    end

`ifdef PS_BC_DBL_EN
    bc_state_e  state_q, state_d;
    logic [5:0] lat_addr_q, lat_addr_d;
    logic [1:0] lat_code_q, lat_code_d;

    always_ff @(posedge clk_dcd) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_addr_q <= 6'd0;
            lat_code_q <= DI_IDLE;
        end else if (bc.ps_flush) begin
            state_q    <= S_IDLE;
        end else if (!bc.ps_stall) begin
            state_q    <= state_d;
            lat_addr_q <= lat_addr_d;
            lat_code_q <= lat_code_d;
        end
    end

    // Second beat reuses the first beat's register pair: same address with the LSB set.
    always_comb begin
        state_d    = state_q;
        lat_addr_d = lat_addr_q;
        lat_code_d = lat_code_q;
        pipe_code  = dec_di;
        pipe_live  = dec_live;
        drr_out    = dec_drr;
        busy       = 1'b0;
        beat       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bc.ps_dblinst && dec_live && dec_uses_ureg) begin
                    state_d    = S_BEAT2;
                    lat_addr_d = dec_addr | 6'd1;
                    lat_code_d = dec_di;
                end
            end
            S_BEAT2: begin
                drr_out   = ureg_to_drr(lat_addr_q);
                pipe_code = lat_code_q;
                pipe_live = 1'b1;
                busy      = 1'b1;
                beat      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    logic unused_dbl;

    assign unused_dbl = ^{bc.ps_dblinst, dec_uses_ureg, dec_addr};
    assign pipe_code  = dec_di;
    assign pipe_live  = dec_live;
    assign drr_out    = dec_drr;
    assign busy       = 1'b0;
    assign beat       = 1'b0;
`endif

    ps_bc_di_pipe #(
        .DEPTH (DI_DEPTH)
    ) u_di_pipe (
        .clk_dcd  (clk_dcd),
        .reset    (reset),
        .hold     (bc.ps_stall),
        .clear    (bc.ps_flush),
        .in_code  (pipe_code),
        .in_live  (pipe_live),
        .out_code (bc.ps_bc_di_slct),
        .out_live (bc.ps_bc_di_vld)
    );

    assign bc.ps_bc_drr_slct = drr_out;
    assign bc.ps_bc_busy     = busy;
    assign bc.ps_bc_beat     = beat;

endmodule

// File: tb/tb_ps_bc_slct_pipe.sv
// tb/tb_ps_bc_slct_pipe.sv - scoreboard bench for ps_bc_slct_pipe (DI_DEPTH=3, UREG_AW=6)
module tb_ps_bc_slct_pipe;
    localparam int D = 3;

    typedef struct {
        logic [1:0] code;
        int         due;
    } exp_t;

    logic clk_dcd = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    bit   mon_en  = 1'b0;
    exp_t sb_q[$];

    ps_bc_slct_pipe_if #(.UREG_AW(6)) bc ();

    ps_bc_slct_pipe #(
        .DI_DEPTH (D),
        .UREG_AW  (6)
    ) dut (
        .clk_dcd (clk_dcd),
        .reset   (reset),
        .bc      (bc)
    );

    always #5 clk_dcd = ~clk_dcd;
    always @(posedge clk_dcd) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_dcd);
        #1;
    endtask

    task automatic clr_in();
        bc.ps_stall = 0; bc.ps_flush = 0; bc.ps_pshstck = 0; bc.ps_popstck = 0;
        bc.ps_imminst = 0; bc.ps_dmimminst = 0; bc.ps_dmiaddinst = 0; bc.ps_dminst = 0;
        bc.ps_urgtrnsinst = 0; bc.ps_dm_wrb = 0; bc.ps_dblinst = 0;
        bc.ps_ureg1_add = '0; bc.ps_ureg2_add = '0;
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] code, input int due);
        exp_t e;
        e.code = code;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    // Check combinational DRR for the current cycle, record the DI expectation, advance.
    task automatic issue(input string nm, input logic [1:0] drr, input logic [1:0] di);
        #1;
        chk(nm, bc.ps_bc_drr_slct, drr);
        push(di, cyc + D);
        tick();
        clr_in();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("busy_idle", {1'b0, bc.ps_bc_busy}, 2'b00);
            tick();
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   prev_stall = 1'b0;
        forever begin
            @(negedge clk_dcd);
            if (mon_en) begin
                if (bc.ps_bc_di_vld === 1'b1 && !prev_stall) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL di_unexpected cyc=%0d got code=%b vld=1 want vld=0", cyc, bc.ps_bc_di_slct);
                    end else begin
                        e = sb_q.pop_front();
                        if (bc.ps_bc_di_slct !== e.code || cyc != e.due) begin
                            bad++;
                            $display("FAIL di_out cyc=%0d got code=%b want code=%b at cyc=%0d",
                                     cyc, bc.ps_bc_di_slct, e.code, e.due);
                        end
                    end
                end else if (bc.ps_bc_di_vld !== 1'b1) begin
                    total++;
                    if (bc.ps_bc_di_vld !== 1'b0 || bc.ps_bc_di_slct !== 2'b11) begin
                        bad++;
                        $display("FAIL di_idle cyc=%0d got code=%b vld=%b want code=11 vld=0",
                                 cyc, bc.ps_bc_di_slct, bc.ps_bc_di_vld);
                    end
                end
            end
            prev_stall = bc.ps_stall;
        end
    endtask

    initial begin
        int c;
        clr_in();
        fork
            monitor();
        join_none
        tick();
        tick();
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("rst_di",   bc.ps_bc_di_slct, 2'b11);
        chk("rst_vld",  {1'b0, bc.ps_bc_di_vld}, 2'b00);
        chk("rst_busy", {1'b0, bc.ps_bc_busy}, 2'b00);
        chk("rst_beat", {1'b0, bc.ps_bc_beat}, 2'b00);
        chk("rst_drr",  bc.ps_bc_drr_slct, 2'b11);
        idle(3);

        // Decode priority and ureg map
        bc.ps_dminst = 1; bc.ps_dm_wrb = 0;
        issue("dm_rd", 2'b11, 2'b00);
        bc.ps_dminst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd6;
        issue("dm_wr_u6", 2'b01, 2'b01);
        bc.ps_urgtrnsinst = 1; bc.ps_ureg2_add = 6'd2;
        issue("urg_u2", 2'b00, 2'b01);
        bc.ps_pshstck = 1; bc.ps_ureg1_add = 6'd0;
        issue("psh_u0", 2'b10, 2'b01);
        bc.ps_imminst = 1; bc.ps_pshstck = 1; bc.ps_ureg1_add = 6'd6;
        issue("imm_over_psh", 2'b11, 2'b10);
        bc.ps_popstck = 1; bc.ps_urgtrnsinst = 1; bc.ps_ureg2_add = 6'd0;
        issue("pop", 2'b01, 2'b01);
        bc.ps_urgtrnsinst = 1; bc.ps_ureg2_add = 6'h16;
        issue("urg_u16", 2'b11, 2'b01);
        bc.ps_dmimminst = 1;
        issue("dmimm", 2'b11, 2'b10);
        bc.ps_dmiaddinst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd7;
        issue("dmiadd_wr_u7", 2'b01, 2'b01);
        bc.ps_pshstck = 1; bc.ps_ureg1_add = 6'd9;
        issue("psh_u9", 2'b11, 2'b01);
        idle(5);

        // Stall: popstck then two stalled cycles
        c = cyc;
        bc.ps_popstck = 1;
        #1; chk("stl_drr0", bc.ps_bc_drr_slct, 2'b01);
        push(2'b01, c + D + 2);
        tick(); clr_in();
        bc.ps_stall = 1; bc.ps_urgtrnsinst = 1; bc.ps_ureg2_add = 6'd6;
        #1; chk("stl_drr1", bc.ps_bc_drr_slct, 2'b01);
        tick(); clr_in();
        bc.ps_stall = 1;
        #1; chk("stl_drr2", bc.ps_bc_drr_slct, 2'b11);
        tick(); clr_in();
        idle(6);

        // Flush squashes in-flight imm and the flush-cycle decode
        c = cyc;
        bc.ps_imminst = 1;
        #1; chk("fl_drr0", bc.ps_bc_drr_slct, 2'b11);
        tick(); clr_in();
        bc.ps_flush = 1; bc.ps_dmiaddinst = 1;
        #1; chk("fl_drr1", bc.ps_bc_drr_slct, 2'b11);
        tick(); clr_in();
        bc.ps_dminst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd1;
        issue("fl_after", 2'b00, 2'b01);
        idle(5);

`ifdef PS_BC_DBL_EN
        // Plain double beat; decode during beat 2 must be ignored
        c = cyc;
        bc.ps_dblinst = 1; bc.ps_dminst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd6;
        #1;
        chk("db_b1_drr",  bc.ps_bc_drr_slct, 2'b01);
        chk("db_b1_busy", {1'b0, bc.ps_bc_busy}, 2'b00);
        push(2'b01, c + D);
        tick(); clr_in();
        bc.ps_imminst = 1;
        #1;
        chk("db_b2_drr",  bc.ps_bc_drr_slct, 2'b01);
        chk("db_b2_busy", {1'b0, bc.ps_bc_busy}, 2'b01);
        chk("db_b2_beat", {1'b0, bc.ps_bc_beat}, 2'b01);
        push(2'b01, c + 1 + D);
        tick(); clr_in();
        #1; chk("db_end_beat", {1'b0, bc.ps_bc_beat}, 2'b00);
        idle(5);

        // Double beat with 2-cycle stall in beat 2
        c = cyc;
        bc.ps_dblinst = 1; bc.ps_urgtrnsinst = 1; bc.ps_ureg2_add = 6'd0;
        #1; chk("ds_b1_drr", bc.ps_bc_drr_slct, 2'b10);
        push(2'b01, c + D + 2);
        tick(); clr_in();
        for (int i = 0; i < 2; i++) begin
            bc.ps_stall = 1;
            #1;
            chk("ds_stl_drr",  bc.ps_bc_drr_slct, 2'b00);
            chk("ds_stl_busy", {1'b0, bc.ps_bc_busy}, 2'b01);
            chk("ds_stl_beat", {1'b0, bc.ps_bc_beat}, 2'b01);
            tick(); clr_in();
        end
        #1;
        chk("ds_b2_busy", {1'b0, bc.ps_bc_busy}, 2'b01);
        push(2'b01, c + 3 + D);
        tick(); clr_in();
        idle(6);

        // Flush in beat 2 of a second transfer
        bc.ps_dblinst = 1; bc.ps_dminst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd6;
        #1; chk("df_b1_drr", bc.ps_bc_drr_slct, 2'b01);
        tick(); clr_in();
        bc.ps_flush = 1;
        #1; chk("df_b2_busy", {1'b0, bc.ps_bc_busy}, 2'b01);
        tick(); clr_in();
        idle(6);

        // Reset mid-beat
        bc.ps_dblinst = 1; bc.ps_pshstck = 1; bc.ps_ureg1_add = 6'd6;
        tick(); clr_in();
        reset = 1'b1;
        #1; chk("dr_b2_busy", {1'b0, bc.ps_bc_busy}, 2'b01);
        tick();
        reset = 1'b0;
        idle(5);

        // dblinst with a non-ureg decode is ignored
        bc.ps_dblinst = 1; bc.ps_dminst = 1;
        issue("dbl_dmrd", 2'b11, 2'b00);
        idle(5);
`else
        bc.ps_dblinst = 1; bc.ps_dminst = 1; bc.ps_dm_wrb = 1; bc.ps_ureg1_add = 6'd6;
        issue("nodbl_b1", 2'b01, 2'b01);
        #1; chk("nodbl_beat", {1'b0, bc.ps_bc_beat}, 2'b00);
        idle(5);
`endif

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
